// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: turns a W-bit unsigned value into packed BCD,
// one bit per clock, and reports how many significant decimal digits the result has.
module bin2bcd_seq #(
  parameter int W      = 256,
  parameter int DIGITS = 78,
  parameter int CW     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            digit_count
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [W-1:0]    bin_r;
  logic [BW-1:0]   scr_r;
  logic [CW-1:0]   cnt_r;

  logic [BW-2:0]   adj_s;
  logic [BW-1:0]   scr_next_s;
  logic [W-1:0]    bin_next_s;
  logic            last_s;
  logic [6:0]      nd_s;

  // The top digit's adjusted MSB is always shifted out, so only its low 3 bits are kept
  // (adding 3 mod 8 gives the same low bits as the 4-bit add).
  function automatic logic [BW-2:0] add3_all(input logic [BW-1:0] v);
    logic [BW-2:0] r;
    r = '0;
    for (int d = 0; d < DIGITS - 1; d++) begin
      r[4*d +: 4] = (v[4*d +: 4] >= 4'd5) ? (v[4*d +: 4] + 4'd3) : v[4*d +: 4];
    end
    r[BW-2 -: 3] = (v[BW-1 -: 4] >= 4'd5) ? 3'(v[BW-2 -: 3] + 3'd3) : v[BW-2 -: 3];
    return r;
  endfunction

  function automatic logic [6:0] sig_digits(input logic [BW-1:0] v);
    logic [6:0] n;
    n = 7'd1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] != 4'd0) begin
        n = 7'(d + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Next-iteration datapath: add-3 correction, then shift {scratch, binary} left by one.
  always_comb begin
    adj_s      = add3_all(scr_r);
    scr_next_s = {adj_s, bin_r[W-1]};
    bin_next_s = {bin_r[W-2:0], 1'b0};
    last_s     = (cnt_r == CW'(W - 1));
    nd_s       = sig_digits(scr_next_s);
  end

  // Control FSM and registered outputs; results are published only on the final iteration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      bin_r       <= '0;
      scr_r       <= '0;
      cnt_r       <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      bcd_out     <= '0;
      digit_count <= 7'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            bin_r   <= bin_in;
            scr_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            ready   <= 1'b0;
            state_r <= CONV;
          end else begin
            state_r <= state_r;
          end
        end
        CONV: begin
          scr_r <= scr_next_s;
          bin_r <= bin_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            bcd_out     <= scr_next_s;
            digit_count <= nd_s;
            busy        <= 1'b0;
            ready       <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= CONV;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed scoreboard bench for bin2bcd_seq: expectations are queued at launch
// and compared when ready rises.
module tb_bin2bcd_seq;

  localparam int W      = 256;
  localparam int DIGITS = 78;
  localparam int CW     = 9;
  localparam int BW     = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [W-1:0]      bin_in;
  logic              busy;
  logic              ready;
  logic [BW-1:0]     bcd_out;
  logic [6:0]        digit_count;

  typedef struct packed {
    logic [BW-1:0] bcd;
    logic [6:0]    nd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .ready(ready), .bcd_out(bcd_out), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference by repeated division by ten.
  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    e.bcd = '0;
    e.nd  = 7'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v != '0) e.nd = 7'(i + 1);
      e.bcd[4*i +: 4] = 4'(v % 256'd10);
      v = v / 256'd10;
    end
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] v, input exp_t e, input bit push);
    logic [BW-1:0] prev;
    @(negedge clk);
    prev   = bcd_out;
    bin_in = v;
    start  = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    bin_in = {8{$urandom}};
    check("accept_busy", BW'(busy), BW'(1'b1));
    check("accept_ready", BW'(ready), BW'(1'b0));
    check("accept_bcd_hold", bcd_out, prev);
  endtask

  task automatic wait_done(input int inj);
    logic [BW-1:0] hold;
    bit            ok;
    int            lat;
    exp_t          e;
    hold = bcd_out;
    ok   = 1'b1;
    lat  = 0;
    while (ready !== 1'b1 && lat < W + 20) begin
      if (lat == inj) begin
        start  = 1'b1;
        bin_in = 256'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (ready !== 1'b1 && (busy !== 1'b1 || bcd_out !== hold)) ok = 1'b0;
    end
    start = 1'b0;
    check("latency", BW'(lat), BW'(W));
    check("busy_and_hold_during_conv", BW'(ok), BW'(1'b1));
    check("done_busy_low", BW'(busy), BW'(1'b0));
    check("sb_nonempty", BW'(sb.size() != 0), BW'(1'b1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("bcd_out", bcd_out, e.bcd);
      check("digit_count", BW'(digit_count), BW'(e.nd));
    end
  endtask

  initial begin
    exp_t          e;
    logic [W-1:0]  v;
    logic [BW-1:0] hold;
    bit            ok;

    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_flags", BW'({busy, ready, digit_count}), '0);
      check("idle_bcd", bcd_out, '0);
    end

    // Small value, then verify the result holds in DONE.
    launch(256'd6, model(256'd6), 1'b1);
    wait_done(-1);
    hold = bcd_out;
    ok   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || bcd_out !== hold || digit_count !== 7'd1) ok = 1'b0;
    end
    check("done_hold_20", BW'(ok), BW'(1'b1));

    v = 256'd1 << 64;
    e.bcd = 312'h18446744073709551616;
    e.nd  = 7'd20;
    launch(v, e, 1'b1);
    wait_done(-1);

    v = '1;
    e.bcd = 312'h115792089237316195423570985008687907853269984665640564039457584007913129639935;
    e.nd  = 7'd78;
    launch(v, e, 1'b1);
    wait_done(-1);

    launch(256'd0, model(256'd0), 1'b1);
    wait_done(-1);

    // Start pulse while converting must be ignored.
    launch(256'd6, model(256'd6), 1'b1);
    wait_done(100);

    launch(256'd9, model(256'd9), 1'b1);
    wait_done(-1);

    // Reset mid-conversion, with start asserted in the reset cycle.
    launch(256'd12345, model(256'd12345), 1'b0);
    repeat (49) @(negedge clk);
    reset  = 1'b0;
    start  = 1'b1;
    bin_in = 256'd77;
    @(negedge clk);
    check("rst_flags", BW'({busy, ready, digit_count}), '0);
    check("rst_bcd", bcd_out, '0);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", BW'({busy, ready, digit_count}), '0);

    v = {8{$urandom}};
    launch(v, model(v), 1'b1);
    wait_done(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
